// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle, 32 cycles per operation, results held in hi/lo until the next completion.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic        is_div_r;
    logic        neg_q_r;
    logic        neg_r_r;
    logic        b_zero_r;
    logic [31:0] a_r;
    logic [31:0] divisor_r;
    logic [63:0] acc_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        dbz_r;

    logic        signed_op_s;
    logic [31:0] mag_a_s;
    logic [31:0] mag_b_s;
    logic [32:0] sum_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;
    logic [63:0] acc_step_s;
    logic [63:0] prod_s;
    logic [31:0] hi_fin_s;
    logic [31:0] lo_fin_s;

    // Operand magnitudes for the signed operations, computed from the live inputs at capture.
    always_comb begin
        signed_op_s = ~op[0];
        if (signed_op_s && a[31]) begin
            mag_a_s = 32'd0 - a;
        end else begin
            mag_a_s = a;
        end
        if (signed_op_s && b[31]) begin
            mag_b_s = 32'd0 - b;
        end else begin
            mag_b_s = b;
        end
    end

    // One iteration: acc holds {partial, multiplier} for multiply, {remainder, dividend} for divide.
    always_comb begin
        sum_s       = 33'd0;
        rem_shift_s = 33'd0;
        diff_s      = 33'd0;
        acc_step_s  = acc_r;
        if (is_div_r) begin
            rem_shift_s = acc_r[63:31];
            diff_s      = rem_shift_s - {1'b0, divisor_r};
            if (!diff_s[32]) begin
                acc_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_step_s = {acc_r[62:0], 1'b0};
            end
        end else begin
            sum_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, divisor_r} : 33'd0);
            acc_step_s = {sum_s, acc_r[31:1]};
        end
    end

    // Sign fix-up of the final iteration's result; divide by zero returns all-ones quotient and a.
    always_comb begin
        prod_s   = 64'd0;
        hi_fin_s = 32'd0;
        lo_fin_s = 32'd0;
        if (is_div_r) begin
            if (b_zero_r) begin
                hi_fin_s = a_r;
                lo_fin_s = 32'hFFFF_FFFF;
            end else begin
                lo_fin_s = neg_q_r ? (32'd0 - acc_step_s[31:0])  : acc_step_s[31:0];
                hi_fin_s = neg_r_r ? (32'd0 - acc_step_s[63:32]) : acc_step_s[63:32];
            end
        end else begin
            prod_s   = neg_q_r ? (64'd0 - acc_step_s) : acc_step_s;
            hi_fin_s = prod_s[63:32];
            lo_fin_s = prod_s[31:0];
        end
    end

    // Control FSM, iteration datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 6'd0;
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            b_zero_r  <= 1'b0;
            a_r       <= 32'd0;
            divisor_r <= 32'd0;
            acc_r     <= 64'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            dbz_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r   <= RUN;
                        cnt_r     <= 6'd0;
                        busy_r    <= 1'b1;
                        is_div_r  <= op[1];
                        a_r       <= a;
                        divisor_r <= op[1] ? mag_b_s : mag_a_s;
                        acc_r     <= {32'd0, (op[1] ? mag_a_s : mag_b_s)};
                        neg_q_r   <= signed_op_s & (a[31] ^ b[31]);
                        neg_r_r   <= signed_op_s & a[31];
                        b_zero_r  <= (b == 32'd0);
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        hi_r    <= hi_fin_s;
                        lo_r    <= lo_fin_s;
                        dbz_r   <= is_div_r & b_zero_r;
                    end else begin
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: operation request, sampled on the rising edge of clk.
REQ-004 SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have port a, input, 32 bits: operand A (multiplicand or dividend), driven from register file read port 1.
REQ-006 SHALL have port b, input, 32 bits: operand B (multiplier or divisor), driven from register file read port 2.
REQ-007 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a result is written.
REQ-009 SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-010 SHALL have port lo, output, 32 bits: product[31:0] or quotient.
REQ-011 SHALL have port div_by_zero, output, 1 bit: the last completed division had b == 0.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, with a 6-bit iteration counter.
REQ-013 SHALL, in IDLE with start=1, capture a, b and op internally, enter RUN and clear the counter; a, b and op are ignored after that edge.
REQ-014 SHALL ignore start while in RUN; no restart and no change to the captured operands.
REQ-015 SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) iteration per RUN cycle, for 32 iterations.
REQ-016 SHALL, on the edge completing iteration 32, write hi, lo and div_by_zero, set done=1 and return to IDLE.
REQ-017 SHALL pulse done for exactly one cycle: high in the cycle that starts 32 edges after the start-sampling edge, low otherwise.
REQ-018 SHALL drive busy=1 from the edge after start is sampled until the edge that asserts done; busy=0 whenever done=1.
REQ-019 SHALL accept a start presented during the done cycle, giving back-to-back operations with no idle gap.
REQ-020 SHALL, for MULT, set {hi,lo} to the 64-bit two's-complement product; for MULTU, to the 64-bit unsigned product.
REQ-021 SHALL, for DIVU, set lo = floor(a/b) and hi = a mod b.
REQ-022 SHALL, for DIV, divide the magnitudes: quotient negated when sign(a) != sign(b); remainder takes the sign of a; the result truncates toward zero.
REQ-023 SHALL, for DIV with a=0x80000000 and b=0xFFFFFFFF, give lo=0x80000000 and hi=0x00000000 with no flag.
REQ-024 SHALL, for DIV or DIVU with b=0, keep the full 32-cycle latency and give lo=0xFFFFFFFF, hi=a and div_by_zero=1.
REQ-025 SHALL set div_by_zero=0 at completion of any MULT/MULTU, and of any division with b != 0.
REQ-026 SHALL hold hi, lo and div_by_zero stable between completions, including throughout RUN.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, counter 0, busy=0, done=0, hi=0, lo=0 and div_by_zero=0, independent of clk.
REQ-028 SHALL, on rst asserted during RUN, abort the operation with no done pulse, and clear hi/lo to 0.
REQ-029 SHALL ignore start on the first rising edge on which rst is already low only if rst deasserted less than the setup time before it; otherwise start on that edge is accepted normally.

Verification
REQ-030 SHALL pass: MULT a=0xFFFFFFFE (-2), b=1300 -> done exactly 32 cycles after the start edge, hi=0xFFFFFFFF, lo=0xFFFFF5D8, div_by_zero=0.
REQ-031 SHALL pass: MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 SHALL pass: DIV a=-2000 (0xFFFFF830), b=3 -> lo=0xFFFFFD66 (-666), hi=0xFFFFFFFE (-2).
REQ-033 SHALL pass: DIVU a=7, b=0 -> after 32 cycles, lo=0xFFFFFFFF, hi=7, div_by_zero=1; a following MULT 3*4 -> hi=0, lo=12, div_by_zero=0.
REQ-034 SHALL pass: start pulsed with new operands at cycle 10 of RUN -> ignored, and the original result is delivered on time; a start issued in the done cycle -> busy is high on the next cycle, and a second done follows 32 cycles later.
REQ-035 SHALL pass: rst pulsed at cycle 15 of RUN -> busy=0, hi=lo=0 immediately, and no done pulse for the aborted operation.
